// File: rtl/dds_pkg.sv
// Shared opcode, FSM state and header-field definitions for the DDS
// command controller.
package dds_pkg;

   typedef enum logic [3:0] {
      NOP       = 4'd0,
      SET_FREQ  = 4'd1,
      SET_PHASE = 4'd2,
      SELECT    = 4'd3,
      LOAD      = 4'd4,
      SET_STEP  = 4'd5
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      PAYLOAD,
      LD_SETUP,
      LD_DATA,
      LD_END
   } state_e;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 28;
   localparam int CH_MSB = 27;
   localparam int CH_LSB = 24;
   localparam int IMM_W  = 12;

endpackage

// File: rtl/dds_sweep_tick.sv
// Free-running prescaler: one-cycle o_tick every PRESCALE clocks.
// Used only when DDS_SWEEP_EN is defined.
module dds_sweep_tick #(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic dds_rstn_sync,
   output logic o_tick
);

   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] r_cnt;
   logic          r_tick;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(PRESCALE - 1));
   assign o_tick = r_tick;

   always_ff @(posedge clk or negedge dds_rstn_sync) begin
      if (!dds_rstn_sync) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dds_cfg_ctrl.sv
// Host command decoder and waveform-RAM load sequencer for the DDS core.
// Optional frequency sweep enabled by defining DDS_SWEEP_EN.
module dds_cfg_ctrl
   import dds_pkg::*;
#(
   parameter int HORIZON_RESOLUTION = 12,
   parameter int ADDER_LOWBIT       = 20,
   parameter int WAVE_STORE         = 2,
   parameter int SWEEP_PRESCALE     = 50000,
   localparam int PW  = HORIZON_RESOLUTION + ADDER_LOWBIT,
   localparam int NCH = 2**WAVE_STORE
) (
   input  logic                          clk,
   input  logic                          dds_rstn_sync,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [31:0]                   cmd_data,
   output logic                          busy,
   output logic                          load_done,
   output logic                          cmd_err,
   output logic [WAVE_STORE-1:0]         wave_sel,
   output logic [NCH*PW-1:0]             freq_ctrl,
   output logic [NCH*HORIZON_RESOLUTION-1:0] phase_ctrl,
   output logic                          wr_enable,
   output logic                          wr_valid,
   output logic [31:0]                   wr_data
);

   localparam int HR = HORIZON_RESOLUTION;
   localparam int NS = 2**HR;

   state_e                r_state, w_next;
   logic                  r_live;
   logic [3:0]            w_op_raw, w_ch_raw;
   logic [WAVE_STORE-1:0] w_ch, r_ch, r_sel, r_wave_sel;
   logic                  w_hs, w_ch_ok, w_op_ok, w_legal, w_last;
   logic                  w_is_freq, w_is_phase, w_is_sel;
   logic                  w_is_load, w_is_step, w_is_pay;
   logic                  r_is_step, w_freq_wr;
   logic [HR:0]           r_cnt;
   logic [PW-1:0]         r_freq [NCH];
   logic [HR-1:0]         r_phase [NCH];
   logic                  r_wr_en, r_wr_valid, r_load_done, r_cmd_err;
   logic [7:0]            r_wr_byte;

   assign w_hs      = cmd_valid & cmd_ready;
   assign w_op_raw  = cmd_data[OP_MSB:OP_LSB];
   assign w_ch_raw  = cmd_data[CH_MSB:CH_LSB];
   assign w_ch      = w_ch_raw[WAVE_STORE-1:0];
   assign w_ch_ok   = ({28'd0, w_ch_raw} < 32'(NCH));
   assign w_is_freq  = (op_e'(w_op_raw) == SET_FREQ);
   assign w_is_phase = (op_e'(w_op_raw) == SET_PHASE);
   assign w_is_sel   = (op_e'(w_op_raw) == SELECT);
   assign w_is_load  = (op_e'(w_op_raw) == LOAD);
   assign w_is_step  = (op_e'(w_op_raw) == SET_STEP);
   assign w_is_pay   = w_is_freq | w_is_step;
`ifdef DDS_SWEEP_EN
   assign w_op_ok = w_is_pay | w_is_phase | w_is_sel | w_is_load;
`else
   assign w_op_ok = w_is_freq | w_is_phase | w_is_sel | w_is_load;
`endif
   assign w_legal = w_op_ok & w_ch_ok;
   assign w_last  = (r_cnt == (HR+1)'(NS - 1));

   assign cmd_ready = r_live &
      (r_state inside {IDLE, PAYLOAD, LD_DATA});
   assign busy      = (r_state != IDLE);
   assign load_done = r_load_done;
   assign cmd_err   = r_cmd_err;
   assign wave_sel  = r_wave_sel;
   assign wr_enable = r_wr_en;
   assign wr_valid  = r_wr_valid;
   assign wr_data   = {24'd0, r_wr_byte};

   always_ff @(posedge clk or negedge dds_rstn_sync) begin
      if (!dds_rstn_sync) r_state <= IDLE;
      else                r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_hs && w_legal) begin
               unique case (1'b1)
                  w_is_pay:  w_next = PAYLOAD;
                  w_is_load: w_next = LD_SETUP;
                  default:   w_next = IDLE;
               endcase
            end
         end
         PAYLOAD:  if (w_hs) w_next = IDLE;
         LD_SETUP: w_next = LD_DATA;
         LD_DATA:  if (w_hs && w_last) w_next = LD_END;
         LD_END:   w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // wave_sel jumps to the target during LD_SETUP so the DDS re-arms
   // its write base while wr_enable is still low.
   always_ff @(posedge clk or negedge dds_rstn_sync) begin
      if (!dds_rstn_sync) begin
         r_live      <= 1'b0;
         r_ch        <= '0;
         r_is_step   <= 1'b0;
         r_sel       <= '0;
         r_wave_sel  <= '0;
         r_cnt       <= '0;
         r_wr_en     <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_wr_byte   <= '0;
         r_load_done <= 1'b0;
         r_cmd_err   <= 1'b0;
         for (int i = 0; i < NCH; i++) r_phase[i] <= '0;
      end else begin
         r_live      <= 1'b1;
         r_cmd_err   <= (r_state == IDLE) && w_hs && !w_legal;
         r_load_done <= (r_state == LD_END);
         r_wr_valid  <= (r_state == LD_DATA) && w_hs;
         r_wr_en     <= (w_next == LD_DATA) || (r_state == LD_DATA);
         if ((r_state == LD_DATA) && w_hs) r_wr_byte <= cmd_data[7:0];
         if ((r_state == IDLE) && w_hs && w_legal) begin
            r_ch      <= w_ch;
            r_is_step <= w_is_step;
            if (w_is_phase) r_phase[w_ch] <= cmd_data[HR-1:0];
            if (w_is_sel) begin
               r_sel      <= w_ch;
               r_wave_sel <= w_ch;
            end
            if (w_is_load) r_wave_sel <= w_ch;
         end
         if (r_state == LD_SETUP)
            r_cnt <= '0;
         else if ((r_state == LD_DATA) && w_hs)
            r_cnt <= r_cnt + 1'b1;
         if (r_state == LD_END) r_wave_sel <= r_sel;
      end
   end

   assign w_freq_wr = (r_state == PAYLOAD) && w_hs && !r_is_step;

`ifdef DDS_SWEEP_EN
   logic          w_tick;
   logic [PW-1:0] r_step [NCH];

   dds_sweep_tick #(
      .PRESCALE(SWEEP_PRESCALE)
   ) u_tick (
      .clk           (clk),
      .dds_rstn_sync (dds_rstn_sync),
      .o_tick        (w_tick)
   );
`else
   localparam int unused_prescale = SWEEP_PRESCALE;
`endif

   always_ff @(posedge clk or negedge dds_rstn_sync) begin
      if (!dds_rstn_sync) begin
         for (int i = 0; i < NCH; i++) begin
            r_freq[i] <= '0;
`ifdef DDS_SWEEP_EN
            r_step[i] <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_freq_wr && (r_ch == WAVE_STORE'(i)))
               r_freq[i] <= PW'(cmd_data);
`ifdef DDS_SWEEP_EN
            else if (w_tick)
               r_freq[i] <= r_freq[i] + r_step[i];
            if ((r_state == PAYLOAD) && w_hs && r_is_step &&
                (r_ch == WAVE_STORE'(i)))
               r_step[i] <= PW'(cmd_data);
`endif
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_out
      assign freq_ctrl[g*PW +: PW]  = r_freq[g];
      assign phase_ctrl[g*HR +: HR] = r_phase[g];
   end

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Directed + randomized bench for dds_cfg_ctrl against an array model.
// Sweep checks run only when DDS_SWEEP_EN is defined.
module tb_dds_cfg_ctrl;

`ifdef DDS_SWEEP_EN
   localparam int SP = 4;
`else
   localparam int SP = 50000;
`endif

   logic         clk = 1'b0;
   logic         dds_rstn_sync;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [31:0]  cmd_data;
   logic         busy, load_done, cmd_err;
   logic [1:0]   wave_sel;
   logic [127:0] freq_ctrl;
   logic [47:0]  phase_ctrl;
   logic         wr_enable, wr_valid;
   logic [31:0]  wr_data;

   dds_cfg_ctrl #(
      .HORIZON_RESOLUTION(12),
      .ADDER_LOWBIT      (20),
      .WAVE_STORE        (2),
      .SWEEP_PRESCALE    (SP)
   ) dut (
      .clk           (clk),
      .dds_rstn_sync (dds_rstn_sync),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_data      (cmd_data),
      .busy          (busy),
      .load_done     (load_done),
      .cmd_err       (cmd_err),
      .wave_sel      (wave_sel),
      .freq_ctrl     (freq_ctrl),
      .phase_ctrl    (phase_ctrl),
      .wr_enable     (wr_enable),
      .wr_valid      (wr_valid),
      .wr_data       (wr_data)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] m_freq [4];
   logic [11:0] m_phase [4];
   logic [1:0]  m_sel;

   logic [31:0] q[$];
   logic [31:0] w;
   int sent, got, done_cnt, bad_en, bad_ws, bad_data;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_freq[i]  = '0;
         m_phase[i] = '0;
      end
      m_sel = '0;
   endtask

   function automatic logic [127:0] exp_freq();
      logic [127:0] v;
      for (int i = 0; i < 4; i++) v[i*32 +: 32] = m_freq[i];
      return v;
   endfunction

   function automatic logic [47:0] exp_phase();
      logic [47:0] v;
      for (int i = 0; i < 4; i++) v[i*12 +: 12] = m_phase[i];
      return v;
   endfunction

   task automatic send(input logic [31:0] word);
      int guard;
      guard     = 0;
      cmd_valid = 1'b1;
      cmd_data  = word;
      while (!cmd_ready && guard < 100) begin
         tick();
         guard++;
      end
      if (guard >= 100) check("send_timeout", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_freq"}, freq_ctrl, exp_freq());
      check({tag, "_phase"}, phase_ctrl, exp_phase());
      check({tag, "_wave_sel"}, wave_sel, m_sel);
   endtask

   initial begin
      dds_rstn_sync = 1'b0;
      cmd_valid     = 1'b0;
      cmd_data      = '0;
      model_reset();
      repeat (3) tick();
      check("rst_ready", cmd_ready, 0);
      check("rst_wr_en", wr_enable, 0);
      check("rst_busy", busy, 0);
      dds_rstn_sync = 1'b1;
      tick();
      check("rel_ready", cmd_ready, 1);
      check("rel_outs", {busy, load_done, cmd_err, wr_enable, wr_valid}, 0);
      check("rel_wr_data", wr_data, 0);
      check_regs("rel");

      // spec vectors
      send(32'h1100_0000);
      check("pay_busy", busy, 1);
      send(32'h0010_0000);
      m_freq[1] = 32'h0010_0000;
      check_regs("set_freq");
      send(32'h2300_0800);
      m_phase[3] = 12'h800;
      check_regs("set_phase");
      check("legal_no_err", cmd_err, 0);

      // randomized register traffic
      for (int k = 0; k < 12; k++) begin
         int op, ch;
         op = $urandom_range(1, 3);
         ch = $urandom_range(0, 3);
         w  = $urandom;
         case (op)
            1: begin
               send({4'd1, 4'(ch), w[23:0]});
               w = $urandom;
               send(w);
               m_freq[ch] = w;
            end
            2: begin
               send({4'd2, 4'(ch), w[23:0]});
               m_phase[ch] = w[11:0];
            end
            default: begin
               send({4'd3, 4'(ch), w[23:0]});
               m_sel = 2'(ch);
            end
         endcase
         check_regs("rand");
      end

      // illegal headers
      for (int k = 0; k < 5; k++) begin
         logic [31:0] hdr;
         case (k)
            0: hdr = 32'h0000_0000;
            1: hdr = 32'h1400_0000;
`ifdef DDS_SWEEP_EN
            2: hdr = 32'h5800_0000;
`else
            2: hdr = 32'h5000_0000;
`endif
            3: hdr = {4'(6 + $urandom_range(0, 9)), 28'h0};
            default: hdr = {4'd2, 4'(4 + $urandom_range(0, 11)), 24'h000123};
         endcase
         send(hdr);
         check("ill_err", cmd_err, 1);
         check("ill_busy", busy, 0);
         tick();
         check("ill_err_pulse", cmd_err, 0);
         check_regs("ill");
      end

      // select then load
      send(32'h3200_0000);
      m_sel = 2'd2;
      check("sel_wave", wave_sel, 2);
      send(32'h4100_0000);
      check("ldsu_wave_sel", wave_sel, 1);
      check("ldsu_wr_en", wr_enable, 0);
      check("ldsu_ready", cmd_ready, 0);
      tick();
      check("ld_win_open", wr_enable, 1);
      sent = 0; got = 0; done_cnt = 0;
      bad_en = 0; bad_ws = 0; bad_data = 0;
      q.delete();
      for (int c = 0; c < 30000 && done_cnt == 0; c++) begin
         if (wr_valid) begin
            got++;
            if (q.size() == 0) bad_data++;
            else begin
               if (wr_data !== q[0]) bad_data++;
               void'(q.pop_front());
            end
         end
         if (load_done) begin
            done_cnt++;
            check("ld_done_wr_en", wr_enable, 0);
            check("ld_done_wave_sel", wave_sel, 2);
            check("ld_done_busy", busy, 0);
         end else begin
            if (!wr_enable) bad_en++;
            if (wave_sel !== 2'd1) bad_ws++;
         end
         if (sent < 4096 && $urandom_range(0, 3) != 0 && cmd_ready) begin
            w         = $urandom;
            cmd_valid = 1'b1;
            cmd_data  = w;
            q.push_back({24'd0, w[7:0]});
            sent++;
         end else begin
            cmd_valid = 1'b0;
         end
         tick();
      end
      cmd_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (load_done) done_cnt++;
         if (wr_valid) got++;
         tick();
      end
      check("ld_samples", got, 4096);
      check("ld_data_bad", bad_data, 0);
      check("ld_en_gap", bad_en, 0);
      check("ld_wave_sel_win", bad_ws, 0);
      check("ld_done_once", done_cnt, 1);
      check_regs("post_load");

      // reset in the middle of a load
      send(32'h4300_0000);
      for (int c = 0; c < 40; c++) begin
         cmd_valid = 1'b1;
         cmd_data  = $urandom;
         tick();
      end
      cmd_valid = 1'b0;
      check("mid_wr_en_pre", wr_enable, 1);
      dds_rstn_sync = 1'b0;
      #1;
      model_reset();
      check("mid_rst_wr_en", wr_enable, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", cmd_ready, 0);
      check_regs("mid_rst");
      tick();
      tick();
      dds_rstn_sync = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (load_done) done_cnt++;
      end
      check("mid_no_done", done_cnt, 0);
      check("mid_ready", cmd_ready, 1);
      check("mid_wr_en", wr_enable, 0);

`ifdef DDS_SWEEP_EN
      send(32'h5000_0000);
      send(32'hFFFF_FFFF);
      begin
         int g;
         g = 0;
         while (freq_ctrl[31:0] == 32'd0 && g < 20) begin
            tick();
            g++;
         end
         check("sweep_wrap", freq_ctrl[31:0], 32'hFFFF_FFFF);
         check("sweep_others", freq_ctrl[127:32], 96'd0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
